// File: rtl/risc_pkg.sv
// Shared types and constants for the one-cycle RISC front end.
package risc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_mod.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid read, valid/ready hand-off to decode.
// Optional MISALIGN_TRAP_EN: misaligned PCs skip the memory read and present a flagged NOP.
//
// state | meaning
// IDLE  | settle cycle after reset, always moves to REQ
// REQ   | request held to imem until gnt; pc_i sampled on the first cycle
// WAIT  | awaiting rvalid; data discarded when a redirect occurred meanwhile
// HOLD  | instruction presented to decode until consumed or flushed
module instr_fetch_mod #(
   parameter int unsigned N         = 10,
   parameter logic [31:0] NOP_INSTR = risc_pkg::NOP_INSTR
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  pc_i,
   input  logic          flush_i,
   output logic          imem_req_o,
   output logic [N-1:0]  imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [31:0]   imem_rdata_i,
   output logic [31:0]   instr_o,
   output logic [N-1:0]  instr_pc_o,
   output logic          instr_valid_o,
   input  logic          instr_ready_i,
   output logic          misalign_o,
   output logic          stall_o
);
   import risc_pkg::*;

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic          r_first;
   logic          r_drop;
   logic          r_valid;
   logic          r_misalign;
   logic [N-1:0]  r_addr;
   logic [N-1:0]  r_instr_pc;
   logic [31:0]   r_instr;

   logic [N-1:0]  w_pc_align;
   logic          w_mis;
   logic          w_drop;

   assign w_pc_align = pc_i & ~{{(N-2){1'b0}}, 2'b11};

`ifdef MISALIGN_TRAP_EN
   assign w_mis = (r_state == REQ) && r_first && (pc_i[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif

   // A redirect in the same cycle as rvalid also kills the returning word.
   assign w_drop = r_drop | flush_i;

   // The PC only settles once REQ is entered, so the first REQ cycle looks at pc_i directly.
   assign imem_addr_o   = (r_state == REQ && r_first) ? w_pc_align : r_addr;
   assign imem_req_o    = (r_state == REQ) && !w_mis;
   assign instr_o       = r_instr;
   assign instr_pc_o    = r_instr_pc;
   assign instr_valid_o = r_valid;
   assign misalign_o    = r_misalign;
   assign stall_o       = ~((r_valid & instr_ready_i) | flush_i);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: w_state_nxt = REQ;
         REQ: begin
            if (w_mis)
               w_state_nxt = flush_i ? REQ : HOLD;
            else if (imem_gnt_i)
               w_state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_rvalid_i)
               w_state_nxt = w_drop ? REQ : HOLD;
         end
         HOLD: begin
            if (instr_ready_i || flush_i)
               w_state_nxt = REQ;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_first    <= 1'b0;
         r_drop     <= 1'b0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
         r_addr     <= '0;
         r_instr_pc <= '0;
         r_instr    <= NOP_INSTR;
      end else begin
         r_state <= w_state_nxt;
         r_first <= (w_state_nxt == REQ) && ((r_state != REQ) || w_mis);

         if (r_state == REQ && r_first)
            r_addr <= w_pc_align;

         case (r_state)
            REQ: begin
               // No request goes out for a trapped PC, so there is nothing to drop.
               if (flush_i && !w_mis)
                  r_drop <= 1'b1;
               if (w_mis && !flush_i) begin
                  r_valid    <= 1'b1;
                  r_instr    <= NOP_INSTR;
                  r_instr_pc <= pc_i;
                  r_misalign <= 1'b1;
               end
            end
            WAIT: begin
               if (flush_i)
                  r_drop <= 1'b1;
               if (imem_rvalid_i) begin
                  if (w_drop) begin
                     r_drop <= 1'b0;
                  end else begin
                     r_valid    <= 1'b1;
                     r_instr    <= imem_rdata_i;
                     r_instr_pc <= r_addr;
                     r_misalign <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (instr_ready_i || flush_i) begin
                  r_valid    <= 1'b0;
                  r_instr    <= NOP_INSTR;
                  r_misalign <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_mod.sv
// Directed bench for instr_fetch_mod; expectations follow MISALIGN_TRAP_EN when defined.
module tb_instr_fetch_mod;

   localparam int unsigned N   = 10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  pc_i;
   logic          flush_i;
   logic          imem_req_o;
   logic [N-1:0]  imem_addr_o;
   logic          imem_gnt_i;
   logic          imem_rvalid_i;
   logic [31:0]   imem_rdata_i;
   logic [31:0]   instr_o;
   logic [N-1:0]  instr_pc_o;
   logic          instr_valid_o;
   logic          instr_ready_i;
   logic          misalign_o;
   logic          stall_o;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_mod #(.N(N), .NOP_INSTR(NOP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .misalign_o    (misalign_o),
      .stall_o       (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_req"},   {31'd0, imem_req_o},    32'd0);
      check_val({tag, "_addr"},  {22'd0, imem_addr_o},   32'd0);
      check_val({tag, "_instr"}, instr_o,                NOP);
      check_val({tag, "_ipc"},   {22'd0, instr_pc_o},    32'd0);
      check_val({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
      check_val({tag, "_mis"},   {31'd0, misalign_o},    32'd0);
   endtask

   // Grant in the current REQ cycle, return rdata on the following cycle; ends in HOLD.
   task automatic fetch_word(input logic [31:0] data);
      imem_gnt_i = 1'b1;
      @(negedge clk);
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = data;
      @(negedge clk);
      imem_rvalid_i = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      pc_i          = '0;
      flush_i       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      instr_ready_i = 1'b0;

      repeat (2) @(negedge clk);
      check_reset_outs("rst");
      rst_n = 1'b1;

      // Test 1: first fetch, grant immediately, data one cycle later
      @(negedge clk);
      check_val("t1_req",   {31'd0, imem_req_o}, 32'd1);
      check_val("t1_addr",  {22'd0, imem_addr_o}, 32'h0);
      check_val("t1_stall", {31'd0, stall_o}, 32'd1);
      fetch_word(32'h0050_0093);
      check_val("t1_valid", {31'd0, instr_valid_o}, 32'd1);
      check_val("t1_instr", instr_o, 32'h0050_0093);
      check_val("t1_ipc",   {22'd0, instr_pc_o}, 32'h0);
      instr_ready_i = 1'b1;
      #1 check_val("t1_stall_consume", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1 instr_ready_i = 1'b0;
      pc_i = 10'h004;

      // Test 2: grant delayed three cycles
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val("t2_req",   {31'd0, imem_req_o}, 32'd1);
         check_val("t2_addr",  {22'd0, imem_addr_o}, 32'h4);
         check_val("t2_stall", {31'd0, stall_o}, 32'd1);
         @(negedge clk);
      end
      check_val("t2_req_at_gnt", {31'd0, imem_req_o}, 32'd1);
      fetch_word(32'h0010_0113);

      // Test 3: decode back-pressure for four cycles
      for (int i = 0; i < 4; i++) begin
         check_val("t3_valid", {31'd0, instr_valid_o}, 32'd1);
         check_val("t3_instr", instr_o, 32'h0010_0113);
         check_val("t3_ipc",   {22'd0, instr_pc_o}, 32'h4);
         check_val("t3_stall", {31'd0, stall_o}, 32'd1);
         @(negedge clk);
      end
      instr_ready_i = 1'b1;
      @(posedge clk);
      #1 instr_ready_i = 1'b0;
      pc_i = 10'h008;
      @(negedge clk);
      check_val("t3_next_req",  {31'd0, imem_req_o}, 32'd1);
      check_val("t3_next_addr", {22'd0, imem_addr_o}, 32'h8);
      check_val("t3_valid_off", {31'd0, instr_valid_o}, 32'd0);

      // Test 4: redirect while waiting for data
      imem_gnt_i = 1'b1;
      @(negedge clk);
      imem_gnt_i = 1'b0;
      flush_i    = 1'b1;
      #1 check_val("t4_stall_flush", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      pc_i = 10'h040;
      @(negedge clk);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'h1111_1111;
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      check_val("t4_valid", {31'd0, instr_valid_o}, 32'd0);
      check_val("t4_instr", instr_o, NOP);
      check_val("t4_req",   {31'd0, imem_req_o}, 32'd1);
      check_val("t4_addr",  {22'd0, imem_addr_o}, 32'h40);

      // Redirect during REQ: address held until grant, then refetch at new PC
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      pc_i = 10'h080;
      @(negedge clk);
      check_val("fr_req_held",  {31'd0, imem_req_o}, 32'd1);
      check_val("fr_addr_held", {22'd0, imem_addr_o}, 32'h40);
      fetch_word(32'h2222_2222);
      check_val("fr_valid", {31'd0, instr_valid_o}, 32'd0);
      check_val("fr_req",   {31'd0, imem_req_o}, 32'd1);
      check_val("fr_addr",  {22'd0, imem_addr_o}, 32'h80);

      // Test 5: reset while waiting, late rvalid must not surface
      imem_gnt_i = 1'b1;
      @(negedge clk);
      imem_gnt_i = 1'b0;
      rst_n      = 1'b0;
      #1 check_reset_outs("t5_rst");
      @(negedge clk);
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      rst_n         = 1'b1;
      @(negedge clk);
      check_val("t5_instr_a", instr_o, NOP);
      check_val("t5_valid_a", {31'd0, instr_valid_o}, 32'd0);
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      check_val("t5_instr_b", instr_o, NOP);
      check_val("t5_valid_b", {31'd0, instr_valid_o}, 32'd0);
      check_val("t5_req",     {31'd0, imem_req_o}, 32'd1);
      check_val("t5_addr",    {22'd0, imem_addr_o}, 32'h80);

      // Flush together with ready in HOLD: single refetch at redirected PC
      fetch_word(32'h3333_3333);
      check_val("fh_valid", {31'd0, instr_valid_o}, 32'd1);
      check_val("fh_instr", instr_o, 32'h3333_3333);
      flush_i       = 1'b1;
      instr_ready_i = 1'b1;
      #1 check_val("fh_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1 flush_i = 1'b0;
      instr_ready_i = 1'b0;
      pc_i = 10'h0C0;
      @(negedge clk);
      check_val("fh_valid_off", {31'd0, instr_valid_o}, 32'd0);
      check_val("fh_req",       {31'd0, imem_req_o}, 32'd1);
      check_val("fh_addr",      {22'd0, imem_addr_o}, 32'hC0);
      fetch_word(32'h4444_4444);
      instr_ready_i = 1'b1;
      @(posedge clk);
      #1 instr_ready_i = 1'b0;
      pc_i = 10'h006;

      // Test 6: misaligned PC
      @(negedge clk);
`ifdef MISALIGN_TRAP_EN
      check_val("t6_no_req", {31'd0, imem_req_o}, 32'd0);
      @(negedge clk);
      check_val("t6_no_req2", {31'd0, imem_req_o}, 32'd0);
      check_val("t6_valid",   {31'd0, instr_valid_o}, 32'd1);
      check_val("t6_mis",     {31'd0, misalign_o}, 32'd1);
      check_val("t6_ipc",     {22'd0, instr_pc_o}, 32'h6);
      check_val("t6_instr",   instr_o, NOP);
      instr_ready_i = 1'b1;
      @(posedge clk);
      #1 instr_ready_i = 1'b0;
      pc_i = 10'h00C;
      @(negedge clk);
      check_val("t6_mis_clr", {31'd0, misalign_o}, 32'd0);
      check_val("t6_req_after", {31'd0, imem_req_o}, 32'd1);
      check_val("t6_addr_after", {22'd0, imem_addr_o}, 32'hC);
`else
      check_val("t6_req",  {31'd0, imem_req_o}, 32'd1);
      check_val("t6_addr", {22'd0, imem_addr_o}, 32'h4);
      fetch_word(32'h5555_5555);
      check_val("t6_valid", {31'd0, instr_valid_o}, 32'd1);
      check_val("t6_mis",   {31'd0, misalign_o}, 32'd0);
      check_val("t6_ipc",   {22'd0, instr_pc_o}, 32'h4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
